// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : Writeback FIFO between result producers and the register-file
//               write port, with pending-write hazard flags and an optional
//               youngest-match bypass (enabled by defining WB_QUEUE_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_reg,
    input  logic [DW-1:0]            in_data,
    input  logic                     wb_stall,
    output logic                     write_en,
    output logic [AW-1:0]            wreg,
    output logic [DW-1:0]            writedata,
    input  logic [AW-1:0]            rega,
    input  logic [AW-1:0]            regb,
    output logic                     pend_a,
    output logic                     pend_b,
    output logic [DW-1:0]            byp_a_data,
    output logic [DW-1:0]            byp_b_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [AW-1:0]   r_reg_mem  [DEPTH];
    logic [DW-1:0]   r_data_mem [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [DEPTH-1:0] w_occ;

    assign w_full   = (r_count == c_CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign in_ready = !rst && !w_full;
    assign w_push   = in_valid && in_ready;
    assign write_en = !w_empty && !wb_stall && !rst;
    assign w_pop    = write_en;
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg_mem[r_wr_ptr]  <= in_reg;
            r_data_mem[r_wr_ptr] <= in_data;
        end
    end

    assign wreg      = (w_empty || rst) ? '0 : r_reg_mem[r_rd_ptr];
    assign writedata = (w_empty || rst) ? '0 : r_data_mem[r_rd_ptr];

    // A slot is live when its distance from the read pointer is below count.
    genvar j;
    generate
        for (j = 0; j < DEPTH; j++) begin : g_slot
            logic [c_PW-1:0] w_age;
            assign w_age    = c_PW'(j) - r_rd_ptr;
            assign w_occ[j] = ({1'b0, w_age} < r_count);
        end
    endgenerate

    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_occ[i] && (r_reg_mem[i] == rega)) pend_a = 1'b1;
            if (w_occ[i] && (r_reg_mem[i] == regb)) pend_b = 1'b1;
        end
        if (rst) begin
            pend_a = 1'b0;
            pend_b = 1'b0;
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    logic [c_PW-1:0] w_idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        byp_a_data = '0;
        byp_b_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + c_PW'(i);
            if ((c_CW'(i) < r_count) && (r_reg_mem[w_idx] == rega)) byp_a_data = r_data_mem[w_idx];
            if ((c_CW'(i) < r_count) && (r_reg_mem[w_idx] == regb)) byp_b_data = r_data_mem[w_idx];
        end
        if (rst) begin
            byp_a_data = '0;
            byp_b_data = '0;
        end
    end
`else
    assign byp_a_data = '0;
    assign byp_b_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_queue
// Description : Self-checking bench for wb_queue against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;
    logic          wb_stall;
    logic          write_en;
    logic [AW-1:0] wreg;
    logic [DW-1:0] writedata;
    logic [AW-1:0] rega;
    logic [AW-1:0] regb;
    logic          pend_a;
    logic          pend_b;
    logic [DW-1:0] byp_a_data;
    logic [DW-1:0] byp_b_data;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } entry_t;
    entry_t mq[$];

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wb_stall(wb_stall), .write_en(write_en), .wreg(wreg), .writedata(writedata),
        .rega(rega), .regb(regb), .pend_a(pend_a), .pend_b(pend_b),
        .byp_a_data(byp_a_data), .byp_b_data(byp_b_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            automatic bit pop  = (mq.size() != 0) && !wb_stall;
            automatic bit push = in_valid && (mq.size() != DEPTH);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{r: in_reg, d: in_data});
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic logic          e_pa = 1'b0;
            automatic logic          e_pb = 1'b0;
            automatic logic [DW-1:0] e_ba = '0;
            automatic logic [DW-1:0] e_bb = '0;
            automatic bit            live = !rst && (mq.size() != 0);
            foreach (mq[k]) begin
                if (mq[k].r == rega) begin e_pa = 1'b1; e_ba = mq[k].d; end
                if (mq[k].r == regb) begin e_pb = 1'b1; e_bb = mq[k].d; end
            end
            if (rst) begin
                e_pa = 1'b0; e_pb = 1'b0; e_ba = '0; e_bb = '0;
            end
`ifndef WB_QUEUE_BYPASS_EN
            e_ba = '0;
            e_bb = '0;
`endif
            chk("count", 32'(count), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(!rst && mq.size() != DEPTH));
            chk("write_en", 32'(write_en), 32'(live && !wb_stall));
            chk("wreg", 32'(wreg), live ? 32'(mq[0].r) : 32'd0);
            chk("writedata", 32'(writedata), live ? 32'(mq[0].d) : 32'd0);
            chk("pend_a", 32'(pend_a), 32'(e_pa));
            chk("pend_b", 32'(pend_b), 32'(e_pb));
            chk("byp_a", 32'(byp_a_data), 32'(e_ba));
            chk("byp_b", 32'(byp_b_data), 32'(e_bb));
        end
    end

    task automatic drive(input bit r, input bit v, input int rg, input int d,
                         input bit s, input int ra, input int rb);
        rst = r; in_valid = v; in_reg = AW'(rg); in_data = DW'(d);
        wb_stall = s; rega = AW'(ra); regb = AW'(rb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_en = 1'b1;

        // Reset state, then a single push drains the following cycle.
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        drive(0, 1, 1, 16'h0001, 0, 0, 0);
        #1;
        chk("push1_no_fwd", 32'(write_en), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("push1_we", 32'(write_en), 32'd1);
        chk("push1_wreg", 32'(wreg), 32'd1);
        chk("push1_wdata", 32'(writedata), 32'd1);
        tick();
        #1;
        chk("push1_cnt0", 32'(count), 32'd0);
        chk("push1_we0", 32'(write_en), 32'd0);

        // Stalled fill: 5th push refused, then 4 ordered writes.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, i, 10 + i, 1, 7, 7);
            #1;
            if (i == 4) begin
                chk("full_ready", 32'(in_ready), 32'd0);
                chk("full_count", 32'(count), 32'd4);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 7, 7);
            #1;
            chk("drain_wreg", 32'(wreg), 32'(i));
            chk("drain_wdata", 32'(writedata), 32'(10 + i));
            tick();
        end

        // Streaming push every cycle across pointer wrap.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(0, 1, i % 8, 16'h100 + i, 0, 0, 0);
            #1;
            chk("stream_cnt_le1", 32'(count <= 1), 32'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Duplicate destination: youngest value visible on bypass.
        drive(0, 1, 4, 16'hAAAA, 1, 4, 5);
        tick();
        drive(0, 1, 4, 16'hBBBB, 1, 4, 5);
        tick();
        drive(0, 0, 0, 0, 1, 4, 5);
        #1;
        chk("dup_pend_a", 32'(pend_a), 32'd1);
        chk("dup_pend_b", 32'(pend_b), 32'd0);
`ifdef WB_QUEUE_BYPASS_EN
        chk("dup_byp_a", 32'(byp_a_data), 32'hBBBB);
`else
        chk("dup_byp_a", 32'(byp_a_data), 32'h0);
`endif

        // Mid-operation reset discards three entries.
        drive(0, 1, 2, 16'h2222, 1, 4, 5);
        tick();
        drive(1, 0, 0, 0, 0, 4, 5);
        #1;
        chk("rst_mid_we", 32'(write_en), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 4, 5);
        #1;
        chk("rst_mid_cnt", 32'(count), 32'd0);
        chk("rst_mid_we_after", 32'(write_en), 32'd0);
        drive(0, 1, 3, 16'h3333, 0, 4, 5);
        tick();
        drive(0, 0, 0, 0, 0, 4, 5);
        #1;
        chk("post_rst_wdata", 32'(writedata), 32'h3333);
        tick();

        // Full with stall released: no push-through, push accepted next cycle.
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, i, 16'h50 + i, 1, 0, 0);
            tick();
        end
        drive(0, 1, 6, 16'h66, 0, 0, 0);
        #1;
        chk("full_rel_ready", 32'(in_ready), 32'd0);
        chk("full_rel_we", 32'(write_en), 32'd1);
        tick();
        #1;
        chk("full_rel_cnt", 32'(count), 32'd3);
        chk("full_rel_ready2", 32'(in_ready), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("full_rel_cnt2", 32'(count), 32'd3);
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            automatic int sp = (i / 500) % 3;
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7), $urandom,
                  (sp == 0) ? ($urandom_range(0, 9) == 0) :
                  (sp == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) < 8),
                  $urandom_range(0, 7), $urandom_range(0, 7));
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
